// File: rtl/neuron_seq_ctrl_if.sv
// Operand stream and shared-neuron bus for the layer sequencer.
// master = sequencer side, slave = input buffer / neuron datapath side.
interface neuron_seq_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int BIAS_W = 13
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [9*DATA_W-1:0]   nc_inputs;
  logic [BIAS_W-1:0]     nc_bias;
  logic                  nc_out;

  modport master (
    input  in_valid, in_data, nc_out,
    output in_ready, nc_inputs, nc_bias
  );

  modport slave (
    output in_valid, in_data, nc_out,
    input  in_ready, nc_inputs, nc_bias
  );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Layer sequencer: packs nine operand lanes per logical neuron, drives the bias
// from a programmable table, waits the neuron latency and gathers result bits.
module neuron_seq_ctrl #(
  parameter int NUM_NEURONS = 16,
  parameter int DATA_W      = 12,
  parameter int BIAS_W      = 13,
  parameter int NC_LAT      = 1,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  input  logic                   bias_we,
  input  logic [IDX_W-1:0]       bias_addr,
  input  logic [BIAS_W-1:0]      bias_wdata,
  output logic [NUM_NEURONS-1:0] result,
  output logic                   done,
  neuron_seq_ctrl_if.master      bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_CAPT = 2'd3;

  localparam int                LAT_W    = (NC_LAT > 1) ? $clog2(NC_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_END  = LAT_W'(NC_LAT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [1:0]                        state;
  logic [3:0]                        lane_cnt;
  logic [IDX_W-1:0]                  neuron_idx;
  logic [LAT_W-1:0]                  wait_cnt;
  logic [8:0][DATA_W-1:0]            lanes;
  logic [BIAS_W-1:0]                 bias_q;
  logic [NUM_NEURONS-1:0][BIAS_W-1:0] bias_mem;
  logic                              start_ok;
  logic                              accept;

  // busy stays high through the done cycle, so a start there is refused
  assign start_ok      = (state == S_IDLE) && start && !busy;
  assign accept        = (state == S_LOAD) && bus.in_valid;
  assign bus.in_ready  = (state == S_LOAD);
  assign bus.nc_inputs = lanes;
  assign bus.nc_bias   = bias_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lane_cnt   <= '0;
      neuron_idx <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      bias_q     <= '0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        S_IDLE: if (start_ok) begin
          busy       <= 1'b1;
          result     <= '0;
          neuron_idx <= '0;
          lane_cnt   <= '0;
          state      <= S_LOAD;
        end
        S_LOAD: if (accept) begin
          if (lane_cnt == 4'd8) begin
            bias_q   <= bias_mem[neuron_idx];
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            lane_cnt <= lane_cnt + 4'd1;
          end
        end
        S_WAIT: begin
          if (wait_cnt == LAT_END) state <= S_CAPT;
          else                     wait_cnt <= wait_cnt + LAT_W'(1);
        end
        S_CAPT: begin
          result[neuron_idx] <= bus.nc_out;
          if (neuron_idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            neuron_idx <= neuron_idx + IDX_W'(1);
            lane_cnt   <= '0;
            state      <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Lanes persist across neurons; each is rewritten before the next WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes <= '0;
    end else begin
      for (int k = 0; k < 9; k++)
        if (accept && lane_cnt == 4'(k)) lanes[k] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  bias_mem <= '0;
    else if (bias_we && !busy) bias_mem[bias_addr] <= bias_wdata;
  end
endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Directed bench for neuron_seq_ctrl with a registered lane0 > lane1 stub neuron.
module tb_neuron_seq_ctrl;
  localparam int NN  = 4;
  localparam int DW  = 12;
  localparam int BW  = 13;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          bias_we;
  logic [1:0]    bias_addr;
  logic [BW-1:0] bias_wdata;
  logic [NN-1:0] result;
  logic          done;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_bias [NN];

  neuron_seq_ctrl_if #(.DATA_W(DW), .BIAS_W(BW)) bus ();

  neuron_seq_ctrl #(.NUM_NEURONS(NN), .DATA_W(DW), .BIAS_W(BW), .NC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
    .result(result), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.nc_out <= (bus.nc_inputs[11:0] > bus.nc_inputs[23:12]);

  function automatic logic [11:0] word(int k, int l, bit uniq);
    if (l == 0) return (k % 2 == 0) ? 12'h200 : 12'h100;
    if (l == 1) return (k % 2 == 0) ? 12'h100 : 12'h200;
    return uniq ? 12'(12'h190 + l) : 12'h19A;
  endfunction

  // pat: 0 = in_valid held high, 1 = 1-on/2-off. inj: 1 = start+bias_we mid-pass,
  // 2 = reset during neuron 2 LOAD. Returns at the negedge where done is seen.
  task automatic run_pass(input bit uniq, input int pat, input int inj, output int done_c);
    int c, wi, hold, kn;
    bit busy_bad, rdy_bad, vec_bad, bias_bad, idle_bad;
    logic [9*DW-1:0] ev;
    c = 0; wi = 0; hold = 0; done_c = -1;
    busy_bad = 0; rdy_bad = 0; vec_bad = 0; bias_bad = 0; idle_bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; bias_we = 1'b0;
    while (c < 400) begin
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1;
      if (bus.in_ready !== ((hold == 0) && (wi < 9*NN))) rdy_bad = 1;
      if (hold > 0) begin
        kn = wi / 9 - 1;
        if (bus.nc_bias !== exp_bias[kn]) bias_bad = 1;
        if (hold == LAT + 1) begin
          for (int l = 0; l < 9; l++) ev[l*DW +: DW] = word(kn, l, uniq);
          if (bus.nc_inputs !== ev) vec_bad = 1;
        end
      end
      if (inj == 2 && wi == 22) begin
        rst = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid: busy=%b done=%b result=%b in_ready=%b, required all 0",
                   busy, done, result, bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) idle_bad = 1;
        end
        checks++;
        if (idle_bad) begin
          errors++;
          $display("FAIL rst_mid_idle: activity seen after reset, required idle with no done");
        end
        bus.in_valid = 1'b0;
        return;
      end
      start      = (inj == 1 && c == 5);
      bias_we    = start;
      bias_addr  = 2'd1;
      bias_wdata = 13'h1FFF;
      if (hold > 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 12'hFFF;
        hold--;
      end else if (wi < 9*NN) begin
        bus.in_valid = (pat == 0) || (c % 3 == 0);
        bus.in_data  = word(wi / 9, wi % 9, uniq);
        if (bus.in_valid && bus.in_ready) begin
          wi++;
          if (wi % 9 == 0) hold = LAT + 1;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      c++;
      @(negedge clk);
    end
    start = 1'b0; bias_we = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (done_c < 0) begin
      errors++;
      $display("FAIL pass_timeout: no done within %0d cycles, required done", c);
    end
    checks++;
    if (busy_bad) begin errors++; $display("FAIL pass_busy: busy low before done, required high"); end
    checks++;
    if (rdy_bad) begin errors++; $display("FAIL pass_in_ready: in_ready differed from LOAD-only window"); end
    checks++;
    if (vec_bad) begin errors++; $display("FAIL pass_lanes: nc_inputs=%h last seen, required lanes in order", bus.nc_inputs); end
    checks++;
    if (bias_bad) begin errors++; $display("FAIL pass_bias: nc_bias=%h in WAIT/CAPTURE, required table value", bus.nc_bias); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 12'h123;
    bias_we = 1'b0; bias_addr = '0; bias_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b done=%b result=%b in_ready=%b, required 0",
               busy, done, result, bus.in_ready);
    end
    checks++;
    if (bus.nc_inputs !== '0 || bus.nc_bias !== '0) begin
      errors++;
      $display("FAIL reset_data: nc_inputs=%h nc_bias=%h, required 0", bus.nc_inputs, bus.nc_bias);
    end
    rst = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.nc_inputs !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b in_ready=%b nc_inputs=%h, required 0",
               busy, bus.in_ready, bus.nc_inputs);
    end
  endtask

  task automatic check_end(input string name, input int done_c, input int want_c);
    checks++;
    if (want_c >= 0 && done_c !== want_c) begin
      errors++;
      $display("FAIL %s_latency: done at %0d, required %0d", name, done_c, want_c);
    end
    checks++;
    if (result !== 4'b0101) begin
      errors++;
      $display("FAIL %s_result: result=%b, required 0101", name, result);
    end
  endtask

  task automatic test_full_pass();
    int dc;
    for (int i = 0; i < NN; i++) exp_bias[i] = '0;
    run_pass(1'b0, 0, 0, dc);
    check_end("full", dc, 44);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_after: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_bias_routing();
    int dc;
    bias_we = 1'b1; bias_addr = 2'd2; bias_wdata = 13'h0ACC;
    @(negedge clk);
    bias_addr = 2'd3; bias_wdata = 13'h05CC;
    exp_bias[2] = 13'h0ACC;
    exp_bias[3] = 13'h05CC;
    run_pass(1'b1, 0, 0, dc);
    check_end("bias", dc, 44);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int dc;
    run_pass(1'b1, 1, 0, dc);
    check_end("bp", dc, -1);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL bp_done_pulse: done=%b, required 0", done); end
  endtask

  task automatic test_ignored();
    int dc;
    run_pass(1'b0, 0, 1, dc);
    check_end("ign", dc, 44);
    @(negedge clk);
    run_pass(1'b0, 0, 0, dc);
    check_end("ign_reread", dc, 44);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dc;
    run_pass(1'b0, 0, 0, dc);
    check_end("b2b", dc, 44);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result !== 4'b0101) begin
      errors++;
      $display("FAIL b2b_ignored: busy=%b result=%b, required 0 0101", busy, result);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || result !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b result=%b in_ready=%b, required 1 0000 1",
               busy, result, bus.in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NN; i++) exp_bias[i] = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dc;
    run_pass(1'b0, 0, 2, dc);
    run_pass(1'b0, 0, 0, dc);
    check_end("after_rst", dc, 44);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_pass();
    test_bias_routing();
    test_backpressure();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/neuron_seq_ctrl.md
# neuron_seq_ctrl

Layer sequencer that time-multiplexes one shared binary-threshold neuron (nine 12-bit fixed-point operand lanes plus a 13-bit bias, one-bit compare output) across `NUM_NEURONS` logical neurons of a layer. It accepts operand words on a valid/ready stream and packs them into nine lanes. It supplies each neuron's bias from an internal programmable bias table, waits the neuron's fixed latency, and collects the one-bit results into a layer output vector. It sits between the layer input buffer and the shared neuron datapath.

## Interface
Parameters:
- `NUM_NEURONS`, 16: logical neurons per layer pass; must be at least 2.
- `DATA_W`, 12: operand lane width.
- `BIAS_W`, 13: bias width.
- `NC_LAT`, 1: cycles from stable operands to valid `nc_out`; must be at least 1.
- `IDX_W`, `$clog2(NUM_NEURONS)`: neuron index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a layer pass; honoured only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle `done` pulses, inclusive.
- `in_valid` in 1: operand word valid.
- `in_ready` out 1: operand word accepted when `in_valid && in_ready`.
- `in_data` in `DATA_W`: operand word.
- `bias_we` in 1: bias table write strobe.
- `bias_addr` in `IDX_W`: bias table write address.
- `bias_wdata` in `BIAS_W`: bias table write data.
- `nc_inputs` out `9*DATA_W`: lane k drives bits `[k*DATA_W +: DATA_W]` to the shared neuron.
- `nc_bias` out `BIAS_W`: bias to the shared neuron.
- `nc_out` in 1: shared neuron compare result.
- `result` out `NUM_NEURONS`: bit n is the result of neuron n.
- `done` out 1: one-cycle pulse when the last neuron's result is captured.

## Operation
- The FSM has four states: IDLE, LOAD, WAIT and CAPTURE.
- **IDLE.** `start` clears `result`, clears `neuron_idx` and the lane counter, and moves to LOAD.
- **LOAD.** `in_ready` is 1.
  - Each accepted word is written to lane `lane_cnt`, in order 0..8.
  - After the 9th accepted word, the FSM moves to WAIT. `nc_bias` is loaded with `bias_mem[neuron_idx]` on that same edge.
  - Cycles with `in_valid` low stall with no state change.
- **WAIT.** `in_ready` is 0. `nc_inputs` and `nc_bias` are held stable. A counter runs for `NC_LAT` cycles, then the FSM moves to CAPTURE.
- **CAPTURE.** `in_ready` is 0. One cycle; `result[neuron_idx]` is set to `nc_out`.
  - If `neuron_idx == NUM_NEURONS-1`: pulse `done`, go to IDLE.
  - Otherwise: increment `neuron_idx`, clear the lane counter, go to LOAD.
- Operand lanes keep their last values between neurons. Lanes are not cleared on neuron change; every lane is overwritten before use.
- **Bias table.** `NUM_NEURONS` x `BIAS_W` registers, all reset to 0.
  - Writes are honoured only when `busy` is 0; a `bias_we` while busy is dropped.
  - A write in the same cycle as an accepted `start` is honoured and is visible to the pass.
- **Ignored events.** `start` while busy is ignored. `in_valid` outside LOAD is not consumed.
- **Widths.** Pure data movement; no arithmetic on operands. No truncation or extension is applied.

## Timing
- **Reset values.** All outputs are 0: `busy`, `in_ready`, `done`, `result`, `nc_inputs`, `nc_bias`. The FSM is in IDLE, all counters are 0, and the bias table is 0.
- **`rst` mid-pass.** The block is in IDLE on the next cycle. `result` is cleared and the partial pass is discarded; no `done` is produced.
- **Per-neuron cycle count** with continuous `in_valid`: 9 (LOAD) + `NC_LAT` (WAIT) + 1 (CAPTURE).
- **Full pass.** `done` is asserted `NUM_NEURONS*(10+NC_LAT)` cycles after the `start` edge.
- **Sampling.** `nc_out` is sampled at the end of CAPTURE, i.e. `NC_LAT+1` edges after the last lane update.
- **`result` stability.** `result` updates one bit per CAPTURE and is stable from the `done` cycle until the next accepted `start`.
- **Back-to-back passes.** `start` asserted in the cycle `done` pulses is ignored, because `busy` is still high. The earliest accepted `start` is the following cycle.

## Test plan
The bench uses `NUM_NEURONS=4`, `NC_LAT=1`, and a stub neuron that registers `nc_out <= (lane0 > lane1)`.
1. **Reset.** Assert `rst` for 2 cycles with `start=1` and `in_valid=1` -> all outputs 0, FSM in IDLE, no word consumed.
2. **Full pass.** Feed neuron k with lane0=0x200, lane1=0x100 for even k, and swapped for odd k; remaining lanes 0x19A; `in_valid` held high -> `result=4'b0101`; `done` is a single cycle exactly 44 cycles after the `start` edge; `busy` falls after `done`.
3. **Bias routing.** Write bias[2]=0x0ACC and bias[3]=0x05CC in IDLE, then run a pass -> `nc_bias=0x0ACC` throughout neuron 2's WAIT and CAPTURE, and 0x05CC for neuron 3; neurons 0 and 1 see 0.
4. **Backpressure.** Toggle `in_valid` with a 1-on/2-off pattern -> lanes are filled in order with no loss or duplication; `in_ready=0` in WAIT and CAPTURE even with `in_valid=1`; the result matches scenario 2.
5. **Ignored commands.** Assert `start` and `bias_we` (addr 1, data 0x1FFF) mid-pass -> the pass is unaffected; after `done`, reading via a new pass shows bias[1] unchanged.
6. **Reset mid-pass.** Assert `rst` during neuron 2's LOAD -> next cycle IDLE, `busy=0`, `result=0`, no `done`; a subsequent full pass produces `4'b0101`.
